mux_sel_rr_arbiter: RTL and testbench
=====================================

// Module: mux_sel_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 8-to-1 1-bit mux between 8 requesters.
//   Drives the mux select from the current grant and holds the grant while the
//   owner keeps its request high. A programmable hold limit forces the grant off
//   so that no single requester starves the others.
//   Sits directly in front of the 8:1 mux: sel feeds the mux select, valid qualifies its output.
// PARAMETERS
//   MAX_HOLD  16  max consecutive grant cycles per win; 0 = no limit (hold until release)
// PORTS
//   clk      in   1  system clock; all state updates on rising edge
//   rst      in   1  synchronous, active-high reset
//   req      in   8  request per channel; req[k]=1 -> channel k wants the mux
//   gnt      out  8  one-hot grant (all-zero when idle); registered
//   sel      out  3  binary index of granted channel, drives mux select; registered
//   valid    out  1  1 while any grant is active (== |gnt); registered
//   timeout  out  1  1-cycle pulse: grant revoked by MAX_HOLD limit; registered
// BEHAVIOUR
//   Reset (rst=1 at an edge, overrides everything, including mid-grant):
//     gnt=0, sel=0, valid=0, timeout=0, state=IDLE, hold_cnt=0,
//     ptr=7 (last winner), so channel 0 has top priority after reset.
//   State machine: IDLE, BUSY.
//   IDLE:
//     - req==0: stay IDLE, outputs 0.
//     - req!=0: winner w = first k with req[k]=1, searching ptr+1, ptr+2, ... mod 8
//       (wraps 7->0). Next edge: gnt=1<<w, sel=w, valid=1, ptr=w, hold_cnt=0,
//       state=BUSY.
//     - Latency: req seen at edge N in IDLE -> grant visible after edge N+1.
//   BUSY (owner o = sel):
//     - req[o]==0: release. Next edge: gnt=0, valid=0, state=IDLE. sel keeps o.
//     - else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: revoke. Next edge: gnt=0,
//       valid=0, timeout=1, state=IDLE.
//     - else: hold_cnt+1, grant unchanged.
//     - Requests of other channels are ignored while BUSY (no preemption).
//   Grant is on for at most MAX_HOLD consecutive cycles. Every release or revoke
//   is followed by exactly one idle cycle (gnt=0) before the next grant.
//   A revoked owner that still requests is an ordinary requester. Because ptr=o,
//   it gets the lowest priority and wins again only if no other channel requests.
//   timeout is high only in the first IDLE cycle after a revoke; 0 otherwise.
//   hold_cnt width is max(1,$clog2(MAX_HOLD+1)) bits. It never wraps: it saturates
//   at release or revoke.
//   sel holds the last owner while idle; downstream must gate on valid.
//   ptr changes only when a new grant is issued.
//   No combinational path from req to any output.
// TESTING
//   1 Reset: rst=1 two cycles, req=FF -> gnt=00, sel=0, valid=0, timeout=0; after
//     rst drops, first grant is gnt=01.
//   2 Single: in IDLE, req=08 at edge N -> gnt=08, sel=3, valid=1 after N+1; drop
//     req[3] at edge M -> gnt=00, valid=0 after M+1.
//   3 Rotation: all 8 channels request; each drops req 2 cycles after its grant and
//     reasserts 1 cycle later -> grant order 0,1,...,7,0,1; one idle gap between grants.
//   4 Timeout: MAX_HOLD=4, req=01 held -> gnt=01 for exactly 4 cycles, timeout=1 in
//     next cycle with gnt=00, then gnt=01 again. With req=03: 0 (4 cyc), timeout,
//     then 1 (4 cyc), timeout, then 0.
//   5 Wrap: last winner 6, ch6 releases with req=41 pending -> next grant ch0.
//     Last winner 2 with req=26 pending -> next grant ch5.
//   6 Reset mid-grant: ch4 granted, rst=1 one cycle -> gnt=00 after that edge;
//     req=FF after reset -> gnt=01. MAX_HOLD=0: req=01 held 100 cycles -> gnt=01
//     throughout, timeout never asserts.

Source files
------------

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 1-bit mux among 8 requesters.
// The grant is held while its owner keeps requesting, up to MAX_HOLD cycles.
module mux_sel_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       valid,
  output logic       timeout
);

  localparam int              HW        = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [HW-1:0]   HOLD_SAT  = '1;
  localparam bit              LIMITED   = (MAX_HOLD != 0);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state;
  logic [2:0]    ptr;
  logic [HW-1:0] hold_cnt;
  logic [2:0]    win;
  logic          win_any;

  // Scan from ptr+8 (== ptr, lowest priority) down to ptr+1 so the last hit
  // is the channel closest after the previous winner.
  always_comb begin
    win     = '0;
    win_any = 1'b0;
    for (int i = 8; i >= 1; i--) begin
      if (req[3'(ptr + 3'(i))]) begin
        win     = 3'(ptr + 3'(i));
        win_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= 3'd7;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            gnt      <= 8'b1 << win;
            sel      <= win;
            valid    <= 1'b1;
            ptr      <= win;
            hold_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // sel is left on the old owner after release; valid gates it downstream.
          if (!req[sel]) begin
            gnt   <= '0;
            valid <= 1'b0;
            state <= IDLE;
          end else if (LIMITED && (hold_cnt == HOLD_LAST)) begin
            gnt     <= '0;
            valid   <= 1'b0;
            timeout <= 1'b1;
            state   <= IDLE;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Directed-vector bench for mux_sel_rr_arbiter with MAX_HOLD = 16, 4 and 0.
// All three instances share clk/rst/req; each sequence checks the relevant one.
module tb_mux_sel_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;

  logic [7:0] gnt16, gnt4, gnt0;
  logic [2:0] sel16, sel4, sel0;
  logic       valid16, valid4, valid0;
  logic       timeout16, timeout4, timeout0;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       timeout;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  mux_sel_rr_arbiter u_dut16 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt16), .sel(sel16), .valid(valid16), .timeout(timeout16)
  );

  mux_sel_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt4), .sel(sel4), .valid(valid4), .timeout(timeout4)
  );

  mux_sel_rr_arbiter #(.MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt0), .sel(sel0), .valid(valid0), .timeout(timeout0)
  );

  always #5 clk = ~clk;

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic applyStimulus(input logic r, input logic [7:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name,
                             input logic [7:0] g, input logic [2:0] s,
                             input logic v, input logic t,
                             input logic [7:0] eg, input logic [2:0] es,
                             input logic ev, input logic et);
    testsRun++;
    if (g !== eg || s !== es || v !== ev || t !== et) begin
      testsFailed++;
      $display("[TB] FAIL %s: got gnt=%h sel=%0d valid=%b timeout=%b, expected gnt=%h sel=%0d valid=%b timeout=%b",
               name, g, s, v, t, eg, es, ev, et);
    end
  endtask

  initial begin
    logic [7:0] onehot;
    logic [7:0] expg [11];
    logic       expt [11];

    rst = 1'b1;
    req = 8'h00;

    // reset, single grant, wrap-around and mid-grant reset on the MAX_HOLD=16 instance
    vecs[0]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h41, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h01, 8'h00, 3'd6, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h41, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'h26, 8'h04, 3'd2, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'h22, 8'h00, 3'd2, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'h26, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 8'h10, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req);
      checkOutput($sformatf("vec%0d", i), gnt16, sel16, valid16, timeout16,
                  vecs[i].gnt, vecs[i].sel, vecs[i].valid, vecs[i].timeout);
    end

    // rotation: all request, owner drops 2 cycles after its grant and reasserts 1 later
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'hFF);
    for (int n = 0; n < 10; n++) begin
      onehot = 8'(1 << (n % 8));
      checkOutput($sformatf("rot_grant%0d", n), gnt16, sel16, valid16, timeout16,
                  onehot, 3'(n % 8), 1'b1, 1'b0);
      applyStimulus(1'b0, 8'hFF);
      checkOutput($sformatf("rot_hold%0d", n), gnt16, sel16, valid16, timeout16,
                  onehot, 3'(n % 8), 1'b1, 1'b0);
      applyStimulus(1'b0, 8'hFF & ~onehot);
      checkOutput($sformatf("rot_gap%0d", n), gnt16, sel16, valid16, timeout16,
                  8'h00, 3'(n % 8), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hFF);
    end

    // MAX_HOLD=4 with a single persistent requester
    expg = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01};
    expt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    applyStimulus(1'b1, 8'h00);
    for (int c = 0; c < 11; c++) begin
      applyStimulus(1'b0, 8'h01);
      checkOutput($sformatf("to1_c%0d", c), gnt4, sel4, valid4, timeout4,
                  expg[c], 3'd0, |expg[c], expt[c]);
    end

    // MAX_HOLD=4 with two persistent requesters alternating after each revoke
    expg = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h01};
    applyStimulus(1'b1, 8'h00);
    for (int c = 0; c < 11; c++) begin
      applyStimulus(1'b0, 8'h03);
      checkOutput($sformatf("to3_c%0d", c), gnt4, sel4, valid4, timeout4,
                  expg[c], (c >= 5 && c <= 9) ? 3'd1 : 3'd0, |expg[c], expt[c]);
    end

    // MAX_HOLD=0 never revokes; the default instance revokes every 16 cycles alongside
    applyStimulus(1'b1, 8'h00);
    for (int c = 0; c < 100; c++) begin
      applyStimulus(1'b0, 8'h01);
      checkOutput($sformatf("nolimit_c%0d", c), gnt0, sel0, valid0, timeout0,
                  8'h01, 3'd0, 1'b1, 1'b0);
      checkOutput($sformatf("hold16_c%0d", c), gnt16, sel16, valid16, timeout16,
                  ((c % 17) == 16) ? 8'h00 : 8'h01, 3'd0,
                  ((c % 17) != 16), ((c % 17) == 16));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
